// File: rtl/sha256_pkg.sv
// Types, round constants and padding helpers shared by the SHA-256 feeder and core.
package sha256_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2
    } feed_state_t;

    // ceil((n+3)/16): room for the delimiter word plus the two length words
    function automatic logic [31:0] num_blocks(input logic [31:0] n);
        return (n + 32'd18) >> 4;
    endfunction

    function automatic word_t pad_word(input logic [31:0] p, input logic [31:0] n);
        logic [63:0] len;
        logic [31:0] total;
        len   = {32'd0, n} << 5;
        total = num_blocks(n) << 4;
        if (p == n)                  return 32'h80000000;
        else if (p == total - 32'd2) return len[63:32];
        else if (p == total - 32'd1) return len[31:0];
        else                         return 32'h0;
    endfunction

endpackage

// File: rtl/sha256_block_feeder.sv
// Reads a message from dpsram, pads it and presents 512-bit blocks; valid 17 cycles after start/handshake.
// blk_data/blk_last/blk_index hold while blk_ready is low; no memory address movement outside FILL.
module sha256_block_feeder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic [7:0]   blk_index,
    output logic         done
);

    localparam logic [31:0] N_W     = NUM_OF_WORDS;
    localparam logic [31:0] W_TOTAL = num_blocks(N_W) << 4;

    feed_state_t  r_state;
    logic [15:0]  r_base;
    logic [15:0]  r_addr;
    logic [31:0]  r_p;
    logic [4:0]   r_cnt;
    logic         r_sel_mem;
    word_t        r_pad;
    block_t       r_buf;
    logic         r_vld;
    logic         r_last;
    logic [7:0]   r_idx;
    logic         r_done;
    word_t        w_pad;
    word_t        w_cap;

    assign w_pad = pad_word(r_p, N_W);
    assign w_cap = r_sel_mem ? mem_read_data : r_pad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_addr    <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_sel_mem <= 1'b0;
            r_pad     <= '0;
            r_buf     <= '0;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_idx     <= '0;
            r_done    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FILL;
                        r_base  <= message_addr;
                        r_addr  <= message_addr;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    r_cnt <= r_cnt + 5'd1;
                    // issue side runs one cycle ahead of capture to cover the read latency
                    if (r_cnt != 5'd16) begin
                        r_sel_mem <= (r_p < N_W);
                        r_pad     <= w_pad;
                        r_p       <= r_p + 32'd1;
                        if (r_p + 32'd1 < N_W)
                            r_addr <= r_base + r_p[15:0] + 16'd1;
                    end
                    if (r_cnt != 5'd0)
                        r_buf <= {r_buf[479:0], w_cap};
                    if (r_cnt == 5'd16) begin
                        r_state <= ST_PRESENT;
                        r_vld   <= 1'b1;
                        r_last  <= (r_p == W_TOTAL);
                    end
                end
                ST_PRESENT: begin
                    if (blk_ready) begin
                        r_vld <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FILL;
                            r_idx   <= r_idx + 8'd1;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign mem_addr  = r_addr;
    assign blk_valid = r_vld;
    assign blk_data  = r_buf;
    assign blk_last  = r_last;
    assign blk_index = r_idx;
    assign done      = r_done;

endmodule
